enemy_mover: RTL and testbench
==============================

// Module: enemy_mover
// PURPOSE
//  Consumes the 2-bit stride phase (Step_Count) from the enemy stride sequencer and moves one enemy
//  toward the player. Owns the enemy position, motion and facing registers and spawn/kill lifecycle.
//  Detects player contact and emits periodic damage pulses. Outputs feed the enemy sprite drawer and
//  the stride sequencer's Obj_X_Pos/Obj_Y_Pos/Obj_X_Motion/Obj_Y_Motion inputs (closes the loop).
// PARAMETERS
//  STEP_SIZE    3'd2    pixels moved per committed stride
//  CONTACT_DIST 9'd2    |dx|<=CONTACT_DIST && |dy|<=CONTACT_DIST counts as contact
//  HIT_PERIOD   6'd30   frames between Hit pulses while in contact
//  X_MIN/X_MAX  9'd8/9'd311   inclusive clamp range for Enemy_X
//  Y_MIN/Y_MAX  9'd8/9'd231   inclusive clamp range for Enemy_Y
// PORTS
//  frame_clk      in   1  frame-rate clock; all state updates on posedge
//  Reset          in   1  asynchronous, active-high
//  Step_Count     in   2  stride phase from sequencer; 3 = commit a move
//  Player_X/Y     in   9  player position, unsigned pixels
//  Spawn          in   1  level, sampled per frame; load Spawn_X/Y when IDLE
//  Spawn_X/Y      in   9  spawn position
//  Kill           in   1  level; return to IDLE (priority over everything but Reset)
//  Enemy_X/Y      out  9  current position
//  Enemy_X_Motion out  9  two's-complement per-commit delta (+STEP, -STEP, 0)
//  Enemy_Y_Motion out  9  same for Y
//  Enemy_Dir      out  2  facing: 0=up 1=down 2=left 3=right
//  Active         out  1  1 in CHASE or CONTACT
//  Hit            out  1  one-frame damage pulse
// BEHAVIOUR
//  Reset (async, any time): IDLE; Enemy_X/Y=0, motions=0, Enemy_Dir=1, Active=0, Hit=0, Hit_Timer=0.
//  States: IDLE -> CHASE on Spawn (loads X/Y from Spawn_X/Y, clamped). CHASE -> CONTACT when
//   the contact box holds on registered position. CONTACT -> CHASE when it no longer holds.
//   Any state -> IDLE on Kill; Kill+Spawn same frame: Kill wins; Spawn ignored outside IDLE.
//  Distance: dx=Player_X-Enemy_X, dy=Player_Y-Enemy_Y in 10-bit signed; no 9-bit wrap.
//  Move (CHASE only, Step_Count==3): larger |d| axis moves; tie -> X axis. Step is
//   min(STEP_SIZE,|d|) (never overshoots the player); result clamped to X/Y MIN..MAX.
//   Moving axis motion = signed applied delta; other axis motion = 0. Enemy_Dir updated to move direction.
//   Step_Count!=3 or no move: position holds, both motions=0, Enemy_Dir holds.
//  CONTACT: no motion. Hit_Timer counts 0..HIT_PERIOD-1 per frame. Hit=1 on the entry frame
//   (timer 0) and each wrap to 0. Timer clears on leaving CONTACT. Hit never asserts elsewhere.
//  Latency: all outputs registered; a Step_Count==3 sample is reflected on Enemy_X/Y next edge.
//  Enemy at clamp edge with player beyond: position holds; motion reports 0 for that frame.
// STRUCTURE
//  Package enemy_pkg: enemy_state_t {E_IDLE,E_CHASE,E_CONTACT}, dir_t {DIR_UP..DIR_RIGHT},
//   COMMIT_STEP=2'd3 shared with the stride sequencer.
//  Sub-module enemy_step_calc (combinational): dx/dy, axis select, clamped next pos, motion, dir.
//  Top: FSM, position/motion/dir registers, Hit_Timer.
// TESTING
//  1 Reset mid-CHASE at X=100 -> async clear: Enemy_X=0, Active=0, Hit=0 before next edge.
//  2 Spawn (50,50), player (80,60), Step_Count cycling 0..3 -> X +2 once per 4 frames; X_Motion=2, Dir=3.
//  3 Tie: enemy (40,40), player (50,50), Step_Count=3 -> X becomes 42, Y stays 40.
//  4 Residual: enemy (99,10), player (100,10), STEP_SIZE=2 -> X=100 (step 1), then CONTACT, Hit pulse.
//  5 Hold contact 61 frames -> Hit at entry, +30, +60 frames; exactly 3 pulses.
//  6 Kill+Spawn same frame in CHASE -> IDLE; Clamp: player X=320, enemy X=311 -> X holds, motion 0.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy mover and the stride sequencer.
package enemy_pkg;
  typedef enum logic [1:0] {
    E_IDLE    = 2'd0,
    E_CHASE   = 2'd1,
    E_CONTACT = 2'd2
  } enemy_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [1:0] COMMIT_STEP = 2'd3;
endpackage

// File: rtl/enemy_step_calc.sv
// Combinational stride planner: picks the dominant axis toward the player and
// produces the clamped next position, applied delta, facing and contact flag.
module enemy_step_calc
  import enemy_pkg::*;
#(
  parameter logic [2:0] STEP_SIZE    = 3'd2,
  parameter logic [8:0] CONTACT_DIST = 9'd2,
  parameter logic [8:0] X_MIN        = 9'd8,
  parameter logic [8:0] X_MAX        = 9'd311,
  parameter logic [8:0] Y_MIN        = 9'd8,
  parameter logic [8:0] Y_MAX        = 9'd231
) (
  input  logic [8:0] enemy_x,
  input  logic [8:0] enemy_y,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  output logic [8:0] next_x,
  output logic [8:0] next_y,
  output logic [8:0] motion_x,
  output logic [8:0] motion_y,
  output dir_t       move_dir,
  output logic       moved,
  output logic       contact
);

  logic signed [9:0]  dx, dy, adx, ady, d_sel, ad_sel, step, delta;
  logic signed [10:0] raw;
  logic [8:0]         cur_sel, sel_lo, sel_hi, tgt;
  logic               x_axis;

  function automatic logic [8:0] sat_pos(input logic signed [10:0] v,
                                         input logic [8:0] lo_b,
                                         input logic [8:0] hi_b);
    if (v < $signed({2'b00, lo_b}))      return lo_b;
    else if (v > $signed({2'b00, hi_b})) return hi_b;
    else                                 return v[8:0];
  endfunction

  always_comb begin
    // 10-bit signed differences so far-apart positions never wrap
    dx      = $signed({1'b0, player_x}) - $signed({1'b0, enemy_x});
    dy      = $signed({1'b0, player_y}) - $signed({1'b0, enemy_y});
    adx     = (dx < 0) ? -dx : dx;
    ady     = (dy < 0) ? -dy : dy;
    contact = (adx <= $signed({1'b0, CONTACT_DIST})) && (ady <= $signed({1'b0, CONTACT_DIST}));
    x_axis  = (adx >= ady);
    d_sel   = x_axis ? dx : dy;
    ad_sel  = x_axis ? adx : ady;
    cur_sel = x_axis ? enemy_x : enemy_y;
    sel_lo  = x_axis ? X_MIN : Y_MIN;
    sel_hi  = x_axis ? X_MAX : Y_MAX;
    step    = (ad_sel < $signed({7'd0, STEP_SIZE})) ? ad_sel : $signed({7'd0, STEP_SIZE});
    raw     = (d_sel < 0) ? $signed({2'b00, cur_sel}) - $signed({1'b0, step})
                          : $signed({2'b00, cur_sel}) + $signed({1'b0, step});
    tgt     = sat_pos(raw, sel_lo, sel_hi);
    delta   = $signed({1'b0, tgt}) - $signed({1'b0, cur_sel});
    moved   = (delta != 10'sd0);
    next_x   = x_axis ? tgt : enemy_x;
    next_y   = x_axis ? enemy_y : tgt;
    motion_x = x_axis ? delta[8:0] : 9'd0;
    motion_y = x_axis ? 9'd0 : delta[8:0];
    if (x_axis) move_dir = (d_sel < 0) ? DIR_LEFT : DIR_RIGHT;
    else        move_dir = (d_sel < 0) ? DIR_UP : DIR_DOWN;
  end

endmodule

// File: rtl/enemy_mover.sv
// Single-enemy chaser: spawn/kill lifecycle, stride-committed motion toward the
// player, and periodic damage pulses while touching the player.
module enemy_mover
  import enemy_pkg::*;
#(
  parameter logic [2:0] STEP_SIZE    = 3'd2,
  parameter logic [8:0] CONTACT_DIST = 9'd2,
  parameter logic [5:0] HIT_PERIOD   = 6'd30,
  parameter logic [8:0] X_MIN        = 9'd8,
  parameter logic [8:0] X_MAX        = 9'd311,
  parameter logic [8:0] Y_MIN        = 9'd8,
  parameter logic [8:0] Y_MAX        = 9'd231
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] Step_Count,
  input  logic [8:0] Player_X,
  input  logic [8:0] Player_Y,
  input  logic       Spawn,
  input  logic [8:0] Spawn_X,
  input  logic [8:0] Spawn_Y,
  input  logic       Kill,
  output logic [8:0] Enemy_X,
  output logic [8:0] Enemy_Y,
  output logic [8:0] Enemy_X_Motion,
  output logic [8:0] Enemy_Y_Motion,
  output logic [1:0] Enemy_Dir,
  output logic       Active,
  output logic       Hit
);

  enemy_state_t state;
  dir_t         dir_q;
  logic [5:0]   hit_timer;
  logic [8:0]   next_x, next_y, motion_x, motion_y;
  dir_t         move_dir;
  logic         moved, contact;

  function automatic logic [8:0] sat_spawn(input logic [8:0] v,
                                           input logic [8:0] lo_b,
                                           input logic [8:0] hi_b);
    if (v < lo_b)      return lo_b;
    else if (v > hi_b) return hi_b;
    else               return v;
  endfunction

  enemy_step_calc #(
    .STEP_SIZE(STEP_SIZE), .CONTACT_DIST(CONTACT_DIST),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_step (
    .enemy_x(Enemy_X), .enemy_y(Enemy_Y),
    .player_x(Player_X), .player_y(Player_Y),
    .next_x(next_x), .next_y(next_y),
    .motion_x(motion_x), .motion_y(motion_y),
    .move_dir(move_dir), .moved(moved), .contact(contact)
  );

  assign Enemy_Dir = dir_q;
  assign Active    = (state != E_IDLE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state          <= E_IDLE;
      Enemy_X        <= '0;
      Enemy_Y        <= '0;
      Enemy_X_Motion <= '0;
      Enemy_Y_Motion <= '0;
      dir_q          <= DIR_DOWN;
      Hit            <= 1'b0;
      hit_timer      <= '0;
    end else begin
      Enemy_X_Motion <= '0;
      Enemy_Y_Motion <= '0;
      Hit            <= 1'b0;
      if (Kill) begin
        state     <= E_IDLE;
        hit_timer <= '0;
      end else begin
        case (state)
          E_IDLE: if (Spawn) begin
            state   <= E_CHASE;
            Enemy_X <= sat_spawn(Spawn_X, X_MIN, X_MAX);
            Enemy_Y <= sat_spawn(Spawn_Y, Y_MIN, Y_MAX);
          end
          E_CHASE: begin
            // A commit on the entry frame still lands; contact is judged on the old position
            if (Step_Count == COMMIT_STEP && moved) begin
              Enemy_X        <= next_x;
              Enemy_Y        <= next_y;
              Enemy_X_Motion <= motion_x;
              Enemy_Y_Motion <= motion_y;
              dir_q          <= move_dir;
            end
            if (contact) begin
              state     <= E_CONTACT;
              hit_timer <= '0;
              Hit       <= 1'b1;
            end
          end
          E_CONTACT: begin
            if (!contact) begin
              state     <= E_CHASE;
              hit_timer <= '0;
            end else if (hit_timer == HIT_PERIOD - 6'd1) begin
              hit_timer <= '0;
              Hit       <= 1'b1;
            end else begin
              hit_timer <= hit_timer + 6'd1;
            end
          end
          default: state <= E_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enemy_mover.sv
// Bench for enemy_mover: vector table through a scoreboard plus hand-written
// sequences for stride cadence, spawn/kill, damage pulses and async reset.
module tb_enemy_mover;
  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [1:0] Step_Count;
  logic [8:0] Player_X, Player_Y, Spawn_X, Spawn_Y;
  logic       Spawn, Kill;
  logic [8:0] Enemy_X, Enemy_Y, Enemy_X_Motion, Enemy_Y_Motion;
  logic [1:0] Enemy_Dir;
  logic       Active, Hit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0] sx, sy, px, py, ex, ey, mx, my;
    logic [1:0] dir;
    logic       hit;
  } vec_t;

  typedef struct {
    int         idx;
    logic [8:0] ex, ey, mx, my;
    logic [1:0] dir;
    logic       hit;
  } exp_t;

  vec_t vt[12];
  exp_t sb[$];

  enemy_mover dut (
    .frame_clk(frame_clk), .Reset(Reset), .Step_Count(Step_Count),
    .Player_X(Player_X), .Player_Y(Player_Y), .Spawn(Spawn),
    .Spawn_X(Spawn_X), .Spawn_Y(Spawn_Y), .Kill(Kill),
    .Enemy_X(Enemy_X), .Enemy_Y(Enemy_Y),
    .Enemy_X_Motion(Enemy_X_Motion), .Enemy_Y_Motion(Enemy_Y_Motion),
    .Enemy_Dir(Enemy_Dir), .Active(Active), .Hit(Hit)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic kill_then_spawn(input logic [8:0] sx, input logic [8:0] sy);
    Step_Count = 2'd0;
    Kill = 1'b1; tick(); Kill = 1'b0;
    Spawn = 1'b1; Spawn_X = sx; Spawn_Y = sy; tick(); Spawn = 1'b0;
  endtask

  task automatic pop_and_compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d_x", e.idx), 16'(Enemy_X), 16'(e.ex));
      check($sformatf("v%0d_y", e.idx), 16'(Enemy_Y), 16'(e.ey));
      check($sformatf("v%0d_mx", e.idx), 16'(Enemy_X_Motion), 16'(e.mx));
      check($sformatf("v%0d_my", e.idx), 16'(Enemy_Y_Motion), 16'(e.my));
      check($sformatf("v%0d_dir", e.idx), 16'(Enemy_Dir), 16'(e.dir));
      check($sformatf("v%0d_hit", e.idx), 16'(Hit), 16'(e.hit));
      check($sformatf("v%0d_active", e.idx), 16'(Active), 16'd1);
    end
  endtask

  initial begin
    int pulses;
    //          sx   sy   px   py   ex   ey   mx      my      dir  hit
    vt[0]  = '{9'd50,  9'd50,  9'd80,  9'd60,  9'd52,  9'd50,  9'd2,   9'd0,   2'd3, 1'b0};
    vt[1]  = '{9'd40,  9'd40,  9'd50,  9'd50,  9'd42,  9'd40,  9'd2,   9'd0,   2'd3, 1'b0};
    vt[2]  = '{9'd99,  9'd10,  9'd100, 9'd10,  9'd100, 9'd10,  9'd1,   9'd0,   2'd3, 1'b1};
    vt[3]  = '{9'd100, 9'd100, 9'd20,  9'd90,  9'd98,  9'd100, 9'h1FE, 9'd0,   2'd2, 1'b0};
    vt[4]  = '{9'd100, 9'd100, 9'd100, 9'd20,  9'd100, 9'd98,  9'd0,   9'h1FE, 2'd0, 1'b0};
    vt[5]  = '{9'd100, 9'd100, 9'd105, 9'd200, 9'd100, 9'd102, 9'd0,   9'd2,   2'd1, 1'b0};
    vt[6]  = '{9'd311, 9'd100, 9'd320, 9'd100, 9'd311, 9'd100, 9'd0,   9'd0,   2'd1, 1'b0};
    vt[7]  = '{9'd8,   9'd100, 9'd0,   9'd100, 9'd8,   9'd100, 9'd0,   9'd0,   2'd1, 1'b0};
    vt[8]  = '{9'd2,   9'd300, 9'd200, 9'd231, 9'd10,  9'd231, 9'd2,   9'd0,   2'd3, 1'b0};
    vt[9]  = '{9'd300, 9'd10,  9'd5,   9'd10,  9'd298, 9'd10,  9'h1FE, 9'd0,   2'd2, 1'b0};
    vt[10] = '{9'd10,  9'd10,  9'd12,  9'd200, 9'd10,  9'd12,  9'd0,   9'd2,   2'd1, 1'b0};
    vt[11] = '{9'd50,  9'd50,  9'd50,  9'd50,  9'd50,  9'd50,  9'd0,   9'd0,   2'd1, 1'b1};

    Reset = 1'b1; Step_Count = 2'd0; Player_X = 9'd0; Player_Y = 9'd0;
    Spawn = 1'b0; Spawn_X = 9'd0; Spawn_Y = 9'd0; Kill = 1'b0;
    tick(); tick();
    check("rst_x", 16'(Enemy_X), 16'd0);
    check("rst_y", 16'(Enemy_Y), 16'd0);
    check("rst_mx", 16'(Enemy_X_Motion), 16'd0);
    check("rst_dir", 16'(Enemy_Dir), 16'd1);
    check("rst_active", 16'(Active), 16'd0);
    check("rst_hit", 16'(Hit), 16'd0);
    Reset = 1'b0;
    tick();
    check("idle_no_spawn", 16'(Active), 16'd0);

    // Single committed stride per vector
    for (int i = 0; i < 12; i++) begin
      kill_then_spawn(vt[i].sx, vt[i].sy);
      Player_X = vt[i].px; Player_Y = vt[i].py; Step_Count = 2'd3;
      sb.push_back('{i, vt[i].ex, vt[i].ey, vt[i].mx, vt[i].my, vt[i].dir, vt[i].hit});
      tick();
      pop_and_compare();
    end

    // Stride cadence: one commit per four frames
    kill_then_spawn(9'd50, 9'd50);
    Player_X = 9'd80; Player_Y = 9'd60;
    for (int f = 0; f < 8; f++) begin
      Step_Count = 2'(f % 4);
      tick();
      check($sformatf("cad%0d_x", f), 16'(Enemy_X), 16'(50 + 2 * ((f + 1) / 4)));
      check($sformatf("cad%0d_mx", f), 16'(Enemy_X_Motion), (f % 4 == 3) ? 16'd2 : 16'd0);
      if (f % 4 == 3) check($sformatf("cad%0d_dir", f), 16'(Enemy_Dir), 16'd3);
    end

    // Spawn ignored in CHASE; Kill beats Spawn; Spawn reloads from IDLE
    Step_Count = 2'd0;
    Spawn = 1'b1; Spawn_X = 9'd200; Spawn_Y = 9'd200; tick();
    check("spawn_ignored_x", 16'(Enemy_X), 16'd54);
    check("spawn_ignored_act", 16'(Active), 16'd1);
    Kill = 1'b1; tick(); Kill = 1'b0;
    check("kill_wins_act", 16'(Active), 16'd0);
    tick(); Spawn = 1'b0;
    check("respawn_x", 16'(Enemy_X), 16'd200);
    check("respawn_act", 16'(Active), 16'd1);

    // Contact: pulses at entry, +30, +60 over 61 frames
    kill_then_spawn(9'd50, 9'd50);
    Player_X = 9'd50; Player_Y = 9'd50;
    pulses = 0;
    for (int f = 0; f < 61; f++) begin
      tick();
      if (Hit === 1'b1) pulses++;
      check($sformatf("hit_f%0d", f), 16'(Hit), (f % 30 == 0) ? 16'd1 : 16'd0);
    end
    check("hit_pulses", 16'(pulses), 16'd3);
    Player_X = 9'd80; tick();
    check("leave_contact_hit", 16'(Hit), 16'd0);
    check("leave_contact_act", 16'(Active), 16'd1);
    Step_Count = 2'd3; tick(); Step_Count = 2'd0;
    check("rechase_x", 16'(Enemy_X), 16'd52);

    // Asynchronous reset mid-chase, observed before the next clock edge
    kill_then_spawn(9'd100, 9'd50);
    Player_X = 9'd200; Player_Y = 9'd50;
    tick();
    check("pre_reset_x", 16'(Enemy_X), 16'd100);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_x", 16'(Enemy_X), 16'd0);
    check("async_rst_act", 16'(Active), 16'd0);
    check("async_rst_hit", 16'(Hit), 16'd0);
    tick();
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
